// File: rtl/cpu_garage_pkg.sv
// Shared sizes, Hack instruction field positions, jump encoding and the ALU helper.
package cpu_garage_pkg;

  localparam int WORD_W    = 16;
  localparam int ROM_DEPTH = 1024;
  localparam int RAM_DEPTH = 16384;
  localparam int PC_W      = $clog2(ROM_DEPTH);
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam int ADDR_W    = 15;

  // C-instruction field positions
  localparam int BIT_CINST = 15;
  localparam int BIT_AM    = 12;
  localparam int BIT_ZX    = 11;
  localparam int BIT_NO    = 6;
  localparam int BIT_DA    = 5;
  localparam int BIT_DD    = 4;
  localparam int BIT_DM    = 3;
  localparam int BIT_JLT   = 2;
  localparam int BIT_JGT   = 0;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    JMP_NONE   = 3'b000,
    JMP_GT     = 3'b001,
    JMP_EQ     = 3'b010,
    JMP_GE     = 3'b011,
    JMP_LT     = 3'b100,
    JMP_NE     = 3'b101,
    JMP_LE     = 3'b110,
    JMP_ALWAYS = 3'b111
  } jump_e;

  typedef struct packed {
    word_t out;
    logic  zr;
    logic  ng;
  } alu_t;

  // ctl = {zx, nx, zy, ny, f, no}, applied in that order
  function automatic alu_t alu(input word_t x_in, input word_t y_in, input logic [5:0] ctl);
    word_t x;
    word_t y;
    word_t o;
    alu_t  r;
    x = x_in;
    y = y_in;
    if (ctl[5]) x = '0;
    if (ctl[4]) x = ~x;
    if (ctl[3]) y = '0;
    if (ctl[2]) y = ~y;
    o = ctl[1] ? (x + y) : (x & y);
    if (ctl[0]) o = ~o;
    r.out = o;
    r.zr  = (o == '0);
    r.ng  = o[WORD_W-1];
    return r;
  endfunction

  function automatic logic jump_taken(input jump_e j, input logic zr, input logic ng);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);
  endfunction

endpackage

// File: rtl/cpu_garage_rom.sv
// Instruction ROM: 1024x16 array mem with combinational read and an optional load port.
module cpu_garage_rom
  import cpu_garage_pkg::*;
(
  input  logic            Clk,
  input  logic            load,
  input  logic [PC_W-1:0] load_addr,
  input  word_t           load_data,
  input  logic [PC_W-1:0] addr,
  output word_t           data
);

  logic [ROM_DEPTH-1:0][WORD_W-1:0] mem;

  always_ff @(posedge Clk) begin
    if (load) mem[load_addr] <= load_data;
  end

  assign data = mem[addr];

endmodule

// File: rtl/cpu_garage.sv
// Hack CPU core plus top-level glue: four ROM ports, 16Kx16 data RAM.
// Optional A+C instruction fusion is enabled by defining AC_FUSION_EN.
module cpu_garage_core
  import cpu_garage_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  word_t             inst,
  input  word_t             inst_next,
  input  word_t             m_data,
  output logic [PC_W-1:0]   pc,
  output logic [ADDR_W-1:0] m_address,
  output logic              we,
  output logic [ADDR_W-1:0] ram_address,
  output word_t             cpu_out_m
);

  logic [PC_W-1:0] pc_reg, pc_next, pc_step;
  word_t           a_reg, a_next, d_reg, d_next;
  word_t           a_eff, c_inst, y;
  logic            fuse, is_c, jump;
  alu_t            alu_res;

`ifdef AC_FUSION_EN
  assign fuse = ~inst[BIT_CINST] & inst_next[BIT_CINST];
`else
  assign fuse = 1'b0;
  logic unused_inst_next;
  assign unused_inst_next = ^inst_next;
`endif

  // When fused, the A-instruction's literal stands in for the A register
  assign a_eff     = fuse ? {1'b0, inst[ADDR_W-1:0]} : a_reg;
  assign c_inst    = fuse ? inst_next : inst;
  assign m_address = a_eff[ADDR_W-1:0];
  assign pc        = pc_reg;

  always_comb begin
    is_c        = c_inst[BIT_CINST];
    y           = c_inst[BIT_AM] ? m_data : a_eff;
    alu_res     = alu(d_reg, y, c_inst[BIT_ZX:BIT_NO]);
    jump        = is_c & jump_taken(jump_e'(c_inst[BIT_JLT:BIT_JGT]), alu_res.zr, alu_res.ng);
    pc_step     = fuse ? PC_W'(2) : PC_W'(1);
    we          = Reset & is_c & c_inst[BIT_DM];
    ram_address = a_eff[ADDR_W-1:0];
    cpu_out_m   = alu_res.out;
    pc_next     = pc_reg + pc_step;
    a_next      = a_reg;
    d_next      = d_reg;
    if (is_c) begin
      if (jump) pc_next = a_eff[PC_W-1:0];
      a_next = c_inst[BIT_DA] ? alu_res.out : a_eff;
      if (c_inst[BIT_DD]) d_next = alu_res.out;
    end else begin
      a_next = {1'b0, inst[ADDR_W-1:0]};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_reg <= '0;
      a_reg  <= '0;
      d_reg  <= '0;
    end else begin
      pc_reg <= pc_next;
      a_reg  <= a_next;
      d_reg  <= d_next;
    end
  end

endmodule

module cpu_garage
  import cpu_garage_pkg::*;
(
  input logic Clk,
  input logic Reset
);

  logic              we;
  logic [ADDR_W-1:0] ram_address;
  word_t             cpu_out_m;
  logic [PC_W-1:0]   pc;
  logic [ADDR_W-1:0] m_address;
  word_t             m_data;
  word_t             rom_data [4];
  logic [PC_W-1:0]   rom_addr [4];
  word_t             ram [RAM_DEPTH];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rom_addr
      assign rom_addr[gi] = pc + PC_W'(gi);
    end
  endgenerate

  cpu_garage_rom rom_inst_0 (.Clk(Clk), .load(1'b0), .load_addr('0), .load_data('0),
                             .addr(rom_addr[0]), .data(rom_data[0]));
  cpu_garage_rom rom_inst_1 (.Clk(Clk), .load(1'b0), .load_addr('0), .load_data('0),
                             .addr(rom_addr[1]), .data(rom_data[1]));
  cpu_garage_rom rom_inst_2 (.Clk(Clk), .load(1'b0), .load_addr('0), .load_data('0),
                             .addr(rom_addr[2]), .data(rom_data[2]));
  cpu_garage_rom rom_inst_3 (.Clk(Clk), .load(1'b0), .load_addr('0), .load_data('0),
                             .addr(rom_addr[3]), .data(rom_data[3]));

  cpu_garage_core cpu_inst (
    .Clk         (Clk),
    .Reset       (Reset),
    .inst        (rom_data[0]),
    .inst_next   (rom_data[1]),
    .m_data      (m_data),
    .pc          (pc),
    .m_address   (m_address),
    .we          (we),
    .ram_address (ram_address),
    .cpu_out_m   (cpu_out_m)
  );

  // RAM is 16K words; address bit 14 aliases onto the same array
  assign m_data = ram[m_address[RAM_AW-1:0]];

  always_ff @(posedge Clk) begin
    if (we) ram[ram_address[RAM_AW-1:0]] <= cpu_out_m;
  end

  logic unused_bits;
  assign unused_bits = ^{rom_data[2], rom_data[3], m_address[ADDR_W-1], ram_address[ADDR_W-1]};

endmodule

// File: tb/tb_cpu_garage.sv
// Directed self-checking bench for cpu_garage; programs are forced into all four ROMs.
module tb_cpu_garage;

  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  logic [1023:0][15:0] prog;
  int          wr_count = 0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  int          base;

`ifdef AC_FUSION_EN
  localparam int N4   = 2;
  localparam int NPRE = 1;
`else
  localparam int N4   = 4;
  localparam int NPRE = 3;
`endif

  always #5 Clk = ~Clk;

  cpu_garage dut (.Clk(Clk), .Reset(Reset));

  always @(negedge Clk) begin
    if (dut.we === 1'b1) begin
      wr_count++;
      wr_addr = 16'(dut.ram_address);
      wr_data = dut.cpu_out_m;
      $display("ram write addr=%h data=%h", wr_addr, wr_data);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic force_roms();
    force dut.rom_inst_0.mem = prog;
    force dut.rom_inst_1.mem = prog;
    force dut.rom_inst_2.mem = prog;
    force dut.rom_inst_3.mem = prog;
  endtask

  function automatic logic [15:0] pcv();
    return 16'(dut.cpu_inst.pc_reg);
  endfunction

  initial begin
    Reset = 1'b0;
    prog  = '0;
    // @2, D=A, @3, D=D+A, @0, M=D, idle loop at 6
    prog[0] = 16'h0002; prog[1] = 16'hEC10; prog[2] = 16'h0003; prog[3] = 16'hE090;
    prog[4] = 16'h0000; prog[5] = 16'hE308; prog[6] = 16'h0006; prog[7] = 16'hEA87;
    force_roms();

    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_pc", pcv(), 16'h0000);
      check("rst_a", dut.cpu_inst.a_reg, 16'h0000);
      check("rst_d", dut.cpu_inst.d_reg, 16'h0000);
      check("rst_we", 16'(dut.we), 16'h0000);
    end
    Reset = 1'b1;
    #1;
    check("fetch_addr", 16'(dut.rom_inst_0.addr), 16'h0000);
    base = wr_count;
    tick();
`ifdef AC_FUSION_EN
    check("first_a", dut.cpu_inst.a_reg, 16'h0002);
    check("first_pc", pcv(), 16'h0002);
    check("first_d", dut.cpu_inst.d_reg, 16'h0002);
`else
    check("first_a", dut.cpu_inst.a_reg, 16'h0002);
    check("first_pc", pcv(), 16'h0001);
    check("first_d", dut.cpu_inst.d_reg, 16'h0000);
`endif
    repeat (20) tick();
    check("add_wr_n", 16'(wr_count - base), 16'h0001);
    check("add_wr_addr", wr_addr, 16'h0000);
    check("add_wr_data", wr_data, 16'h0005);
    check("add_d", dut.cpu_inst.d_reg, 16'h0005);

    // @7, D=A, @10, D;JGT  -> jump to 10
    Reset = 1'b0;
    tick();
    prog = '0;
    prog[0] = 16'h0007; prog[1] = 16'hEC10; prog[2] = 16'h000A; prog[3] = 16'hE301;
    prog[4] = 16'h0004; prog[5] = 16'hEA87; prog[10] = 16'h000A; prog[11] = 16'hEA87;
    force_roms();
    Reset = 1'b1;
    repeat (N4) tick();
    check("jgt_pc", pcv(), 16'h000A);

    // same with D;JLT -> fall through to 4
    Reset = 1'b0;
    tick();
    prog[3] = 16'hE304;
    force_roms();
    Reset = 1'b1;
    repeat (N4) tick();
    check("jlt_pc", pcv(), 16'h0004);

    // @100, M=-1, @100, D=M
    Reset = 1'b0;
    tick();
    prog = '0;
    prog[0] = 16'h0064; prog[1] = 16'hEE88; prog[2] = 16'h0064; prog[3] = 16'hFC10;
    prog[4] = 16'h0004; prog[5] = 16'hEA87;
    force_roms();
    base = wr_count;
    Reset = 1'b1;
    repeat (20) tick();
    check("neg_wr_n", 16'(wr_count - base), 16'h0001);
    check("neg_wr_addr", wr_addr, 16'h0064);
    check("neg_wr_data", wr_data, 16'hFFFF);
    check("neg_d", dut.cpu_inst.d_reg, 16'hFFFF);

    // @5, D=A : fused in one edge, otherwise two
    Reset = 1'b0;
    tick();
    prog = '0;
    prog[0] = 16'h0005; prog[1] = 16'hEC10; prog[2] = 16'h0002; prog[3] = 16'hEA87;
    force_roms();
    Reset = 1'b1;
    tick();
`ifdef AC_FUSION_EN
    check("fuse_d", dut.cpu_inst.d_reg, 16'h0005);
    check("fuse_pc", pcv(), 16'h0002);
`else
    check("step1_d", dut.cpu_inst.d_reg, 16'h0000);
    check("step1_pc", pcv(), 16'h0001);
    tick();
    check("step2_d", dut.cpu_inst.d_reg, 16'h0005);
    check("step2_pc", pcv(), 16'h0002);
`endif

    // @9, D=A, @20, M=D with reset asserted during M=D
    Reset = 1'b0;
    tick();
    prog = '0;
    prog[0] = 16'h0009; prog[1] = 16'hEC10; prog[2] = 16'h0014; prog[3] = 16'hE308;
    prog[4] = 16'h0004; prog[5] = 16'hEA87;
    force_roms();
    base = wr_count;
    Reset = 1'b1;
    repeat (NPRE) tick();
`ifdef AC_FUSION_EN
    check("pre_pc", pcv(), 16'h0002);
`else
    check("pre_pc", pcv(), 16'h0003);
`endif
    check("pre_we", 16'(dut.we), 16'h0001);
    Reset = 1'b0;
    #1;
    check("rstmid_we", 16'(dut.we), 16'h0000);
    tick();
    check("rstmid_pc", pcv(), 16'h0000);
    check("rstmid_a", dut.cpu_inst.a_reg, 16'h0000);
    check("rstmid_d", dut.cpu_inst.d_reg, 16'h0000);
    check("rstmid_wr_n", 16'(wr_count - base), 16'h0000);
    Reset = 1'b1;
    repeat (10) tick();
    check("rerun_wr_n", 16'(wr_count - base), 16'h0001);
    check("rerun_wr_addr", wr_addr, 16'h0014);
    check("rerun_wr_data", wr_data, 16'h0009);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_garage.md
CPU_GARAGE -- requirements
Module: cpu_garage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named as below.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-low reset; Reset==0 at a rising Clk edge resets.
REQ-004 The block SHALL have no other top-level ports; memory traffic is observed through internal signals we (1 bit), ram_address (15 bits) and cpu_out_m (16 bits), which keep these exact names.
REQ-005 The block SHALL contain instances rom_inst_0..rom_inst_3 of the ROM sub-module, each with a 1024x16 array named mem, loadable by hierarchical force; it SHALL also contain a core instance named cpu_inst.

Function
REQ-006 The block SHALL implement the Hack ISA on 16-bit words; PC is 10 bits and wraps 1023->0.
REQ-007 Instruction bit15=0 (A-instruction) SHALL load A <= {0, inst[14:0]}, then PC <= PC+1.
REQ-008 Instruction bit15=1 (C-instruction) SHALL decode as a = inst[12], zx nx zy ny f no = inst[11:6], dest A D M = inst[5:3], jump lt eq gt = inst[2:0]; bits 14:13 are ignored.
REQ-009 ALU SHALL take x=D and y = (a ? M : A), applying zx, nx, zy, ny, f (1=add mod 2^16, 0=AND) and no in that order; zr = (out==0); ng = out[15].
REQ-010 M SHALL be a combinational read of the data RAM at A[14:0]; data RAM is 16384x16, written at the rising edge when we=1, and all words are 0 after power-up.
REQ-011 For a C-instruction with dest M set: we=1, ram_address=A[14:0] (pre-instruction A), cpu_out_m=ALU out; otherwise we=0.
REQ-012 Dest A and D SHALL update at the same edge as the RAM write, using values from before the edge.
REQ-013 Jump is taken iff (lt&ng)|(eq&zr)|(gt&!zr&!ng); target = pre-instruction A[9:0]; otherwise PC <= PC+1.
REQ-014 Exactly one instruction SHALL retire per cycle, except as in REQ-018.
REQ-015 Instruction word 0 (@0) SHALL behave as a normal A-instruction; there is no halt instruction, and an endless jump loop is the idle condition.

Reset
REQ-016 While Reset==0 at an edge: PC, A and D SHALL become 0, and we SHALL be 0 in that cycle; RAM contents are retained.
REQ-017 Reset asserted mid-program SHALL discard the current instruction, including any RAM write; execution restarts at ROM address 0 on the first edge with Reset==1.

Configuration
REQ-018 With macro AC_FUSION_EN defined: if ROM[PC] is an A-instruction and ROM[PC+1] is a C-instruction, both SHALL retire in one cycle.
- The A value feeds the C-instruction's A, M, ram_address and jump target.
- A ends as the fused value unless dest A overrides it.
- PC advances by 2 (mod 1024) unless the jump is taken.
REQ-019 Without AC_FUSION_EN: strictly one instruction per cycle, and rom_inst_1..3 outputs are unused.
REQ-020 In both builds, rom_inst_k SHALL be addressed with (PC+k) mod 1024, and all four ROMs hold identical contents.

Structure
REQ-021 A shared package SHALL hold:
- the ROM depth (1024) and RAM depth (16384);
- word width (16);
- C-instruction field positions;
- the jump-condition encoding.
REQ-022 The ROM (1024x16 array mem, combinational read) SHALL be the one sub-module.
REQ-023 The core, the data RAM and the glue logic SHALL live in cpu_garage and cpu_inst.

Verification
REQ-024 Reset held low for 4 cycles, then released -> PC=0, A=0, D=0 and we=0 throughout reset; the first fetch is from address 0.
REQ-025 Program @2, D=A, @3, D=D+A, @0, M=D -> exactly one write: ram_address=0, cpu_out_m=5; then D=5.
REQ-026 Program @7, D=A, @10, D;JGT -> PC becomes 10.
- The same program with D;JLT -> falls through to PC=4.
REQ-027 Program @100, M=-1, then @100, D=M -> write at ram_address=0x0064 of 0xFFFF; then D=0xFFFF.
REQ-028 With AC_FUSION_EN, program @5, D=A -> both retire in one cycle.
- D=5 and PC=2 after a single edge.
- Without AC_FUSION_EN, the same state takes 2 edges.
REQ-029 Reset asserted in the same cycle as an M=D instruction -> no RAM write; PC=0 at the next edge.
